mkio_tx_encoder: RTL and testbench



---
 rtl/mkio_pkg.sv | 32 +++
 rtl/mkio_tx_encoder_if.sv | 22 ++
 rtl/mkio_half_bit_tick.sv | 26 ++
 rtl/mkio_tx_encoder.sv | 88 ++++++++
 tb/tb_mkio_tx_encoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO Manchester-II transmit path:
// state encoding, word timing constants and the per-word half-bit pattern.
package mkio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_PAR
   } tx_state_t;

   localparam int SYNC_HALF_BITS = 6;
   localparam int DATA_HALF_BITS = 32;
   localparam int WORD_HALF_BITS = 40;

   // One bit per half-bit, first half-bit in the MSB; 1 = line high.
   localparam logic [SYNC_HALF_BITS-1:0] SYNC_CMD  = 6'b111000;
   localparam logic [SYNC_HALF_BITS-1:0] SYNC_DATA = 6'b000111;

   // Full 40 half-bit line sequence of a word, first half-bit in the MSB.
   function automatic logic [WORD_HALF_BITS-1:0] word_pattern(input logic [15:0] data,
                                                             input logic        cd);
      logic [DATA_HALF_BITS-1:0] body;
      logic                      par;
      for (int i = 0; i < 16; i++) begin
         body[2*i +: 2] = data[i] ? 2'b10 : 2'b01;
      end
      par = ~^data;
      return {cd ? SYNC_DATA : SYNC_CMD, body, par ? 2'b10 : 2'b01};
   endfunction

endpackage

// File: rtl/mkio_tx_encoder_if.sv
// Device-side request / line-side status bundle of the MKIO word encoder.
interface mkio_tx_if;
   logic [15:0] tx_data;
   logic        tx_cd;
   logic        tx_ready;
   logic        tx_p;
   logic        tx_n;
   logic        tx_en;
   logic        busy;
   logic        done;
   logic        drop;

   modport master (
      output tx_data, tx_cd, tx_ready,
      input  tx_p, tx_n, tx_en, busy, done, drop
   );

   modport slave (
      input  tx_data, tx_cd, tx_ready,
      output tx_p, tx_n, tx_en, busy, done, drop
   );
endinterface

// File: rtl/mkio_half_bit_tick.sv
// Half-bit divider: counts 0..CLK_DIV-1 while running and flags the terminal count.
module mkio_half_bit_tick #(
   parameter int CLK_DIV = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   logic [7:0] div_cnt;

   assign tick = run && (div_cnt == 8'(CLK_DIV - 1));

   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div_cnt <= '0;
      end else if (run) begin
         div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/mkio_tx_encoder.sv
// MKIO / MIL-STD-1553 Manchester-II word encoder: sync, 16 data bits MSB first,
// odd parity, onto a registered differential driver pair.
module mkio_tx_encoder
   import mkio_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic     clk,
   input  logic     reset,
   mkio_tx_if.slave bus
);

   tx_state_t                 state;
   logic                      rdy_q;
   logic [5:0]                half_cnt;
   logic [WORD_HALF_BITS-2:0] shift_q;
   logic [WORD_HALF_BITS-1:0] launch_pat;
   logic                      request;
   logic                      accept;
   logic                      run;
   logic                      tick;

   assign request    = bus.tx_ready & ~rdy_q;
   assign accept     = request && (state == ST_IDLE);
   assign run        = (state != ST_IDLE);
   assign launch_pat = word_pattern(bus.tx_data, bus.tx_cd);

   mkio_half_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .run   (run),
      .tick  (tick)
   );

   // Outputs are loaded with the level of the half-bit that starts next cycle,
   // so the line is driven straight from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: rdy_q resets high so a request held across reset is not an edge.
         rdy_q     <= 1'b1;
         state     <= ST_IDLE;
         half_cnt  <= '0;
         shift_q   <= '0;
         bus.tx_p  <= 1'b0;
         bus.tx_n  <= 1'b0;
         bus.tx_en <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.drop  <= 1'b0;
      end else begin
         rdy_q    <= bus.tx_ready;
         bus.done <= 1'b0;
         bus.drop <= request && run;

         if (accept) begin
            state     <= ST_SYNC;
            half_cnt  <= '0;
            shift_q   <= launch_pat[WORD_HALF_BITS-2:0];
            bus.tx_p  <= launch_pat[WORD_HALF_BITS-1];
            bus.tx_n  <= ~launch_pat[WORD_HALF_BITS-1];
            bus.tx_en <= 1'b1;
            bus.busy  <= 1'b1;
         end else if (run && tick) begin
            if (half_cnt == 6'(WORD_HALF_BITS - 1)) begin
               state     <= ST_IDLE;
               bus.tx_p  <= 1'b0;
               bus.tx_n  <= 1'b0;
               bus.tx_en <= 1'b0;
               bus.busy  <= 1'b0;
               bus.done  <= 1'b1;
            end else begin
               half_cnt <= half_cnt + 6'd1;
               shift_q  <= {shift_q[WORD_HALF_BITS-3:0], 1'b0};
               bus.tx_p <= shift_q[WORD_HALF_BITS-2];
               bus.tx_n <= ~shift_q[WORD_HALF_BITS-2];
               if (state == ST_SYNC && half_cnt == 6'(SYNC_HALF_BITS - 1)) begin
                  state <= ST_DATA;
               end else if (state == ST_DATA &&
                            half_cnt == 6'(SYNC_HALF_BITS + DATA_HALF_BITS - 1)) begin
                  state <= ST_PAR;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mkio_tx_encoder.sv
// Bench for mkio_tx_encoder: cycle-level behavioural model plus directed and random requests.
module tb_mkio_tx_encoder;
   localparam int D = 2;
   localparam int WORD_CYCLES = 40 * D;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mkio_tx_if bus ();

   mkio_tx_encoder #(.CLK_DIV(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Half-bit levels of a word straight from the line-coding rules; element 39 first.
   function automatic logic [39:0] model_halves(input logic [15:0] d, input logic cd);
      bit         q[$];
      int         ones;
      bit         b;
      bit         pb;
      logic [39:0] r;
      ones = 0;
      for (int j = 0; j < 3; j++) q.push_back(!cd);
      for (int j = 0; j < 3; j++) q.push_back(cd);
      for (int i = 15; i >= 0; i--) begin
         b = ((d >> i) & 16'd1) != 0;
         if (b) ones++;
         q.push_back(b);
         q.push_back(!b);
      end
      pb = (ones % 2) == 0;
      q.push_back(pb);
      q.push_back(!pb);
      for (int j = 0; j < 40; j++) r[39-j] = q[j];
      return r;
   endfunction

   // Reference model state, stepped once per rising edge.
   bit          m_prev = 1'b1;
   bit          m_active = 1'b0;
   int          m_n = 0;
   logic [39:0] m_pat = '0;
   bit          m_done = 1'b0;
   bit          m_drop = 1'b0;

   task automatic model_step(input logic rst, input logic rdy, input logic [15:0] d, input logic cd);
      bit req;
      bit was;
      m_done = 1'b0;
      m_drop = 1'b0;
      if (rst) begin
         m_prev   = 1'b1;
         m_active = 1'b0;
         return;
      end
      req    = rdy && !m_prev;
      m_prev = rdy;
      was    = m_active;
      if (req && was) m_drop = 1'b1;
      if (was) begin
         m_n++;
         if (m_n == WORD_CYCLES) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      if (req && !was) begin
         m_active = 1'b1;
         m_n      = 0;
         m_pat    = model_halves(d, cd);
      end
   endtask

   int cyc = 0;
   int busy_cnt, done_cnt, drop_cnt, en_cnt, pn_bad;
   int drop_cyc, busy_start_cyc;
   int gap_run = 1000;
   int last_gap = -1;
   bit prev_en = 1'b0;
   bit prev_busy = 1'b0;

   task automatic clear_counts();
      busy_cnt = 0; done_cnt = 0; drop_cnt = 0; en_cnt = 0; pn_bad = 0;
      drop_cyc = -1; busy_start_cyc = -1; last_gap = -1;
   endtask

   // Compare process: model advanced at the edge, DUT sampled half a cycle later.
   initial begin
      logic [5:0] exp_v;
      logic [5:0] act_v;
      logic       lvl;
      clear_counts();
      forever begin
         @(posedge clk);
         cyc++;
         model_step(reset, bus.tx_ready, bus.tx_data, bus.tx_cd);
         @(negedge clk);
         lvl   = m_active ? m_pat[39 - m_n / D] : 1'b0;
         exp_v = {m_active, lvl, m_active & ~lvl, m_active, m_done, m_drop};
         act_v = {bus.tx_en, bus.tx_p, bus.tx_n, bus.busy, bus.done, bus.drop};
         check($sformatf("outputs{en,p,n,busy,done,drop}@%0d", cyc), 64'(act_v), 64'(exp_v));
         busy_cnt += int'(bus.busy);
         done_cnt += int'(bus.done);
         drop_cnt += int'(bus.drop);
         en_cnt   += int'(bus.tx_en);
         if (bus.drop === 1'b1) drop_cyc = cyc;
         if (bus.busy === 1'b1 && !prev_busy) busy_start_cyc = cyc;
         if (bus.tx_en === 1'b1 && bus.tx_n === bus.tx_p) pn_bad++;
         if (bus.tx_en !== 1'b1) gap_run++;
         else begin
            if (!prev_en) last_gap = gap_run;
            gap_run = 0;
         end
         prev_en   = (bus.tx_en === 1'b1);
         prev_busy = (bus.busy === 1'b1);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit found;
      bus.tx_ready = 1'b0;
      bus.tx_data  = '0;
      bus.tx_cd    = 1'b0;
      reset        = 1'b1;

      check("pin_0800_cmd", 64'(model_halves(16'h0800, 1'b0)),
            64'(40'b111000_01010101_10_0101010101010101010101_01));
      check("pin_ffff_data", 64'(model_halves(16'hFFFF, 1'b1)),
            64'(40'b000111_10101010101010101010101010101010_10));
      check("pin_0000_cmd", 64'(model_halves(16'h0000, 1'b0)),
            64'(40'b111000_01010101010101010101010101010101_10));

      cycles(3);
      check("reset_outputs", 64'({bus.tx_en, bus.tx_p, bus.tx_n, bus.busy, bus.done, bus.drop}), 64'd0);
      reset = 1'b0;
      cycles(2);

      // Single command word.
      clear_counts();
      bus.tx_data = 16'h0800; bus.tx_cd = 1'b0; bus.tx_ready = 1'b1;
      cycles(1);
      bus.tx_ready = 1'b0;
      cycles(90);
      check("s1_busy_cycles", 64'(busy_cnt), 64'(WORD_CYCLES));
      check("s1_done_pulses", 64'(done_cnt), 64'd1);

      // Data sync, all ones.
      clear_counts();
      bus.tx_data = 16'hFFFF; bus.tx_cd = 1'b1; bus.tx_ready = 1'b1;
      cycles(1);
      bus.tx_ready = 1'b0;
      cycles(90);
      check("s2_differential", 64'(pn_bad), 64'd0);
      check("s2_done_pulses", 64'(done_cnt), 64'd1);

      // Request during busy is dropped.
      clear_counts();
      bus.tx_data = 16'h1234; bus.tx_cd = 1'b0; bus.tx_ready = 1'b1;
      cycles(2);
      bus.tx_ready = 1'b0;
      cycles(8);
      bus.tx_ready = 1'b1;
      cycles(100);
      check("s3_drop_pulses", 64'(drop_cnt), 64'd1);
      check("s3_done_pulses", 64'(done_cnt), 64'd1);
      check("s3_drop_offset", 64'(drop_cyc - busy_start_cyc), 64'd10);
      bus.tx_ready = 1'b0;
      cycles(2);

      // Back-to-back: request on the done cycle.
      clear_counts();
      bus.tx_data = 16'hA5C3; bus.tx_cd = 1'b1; bus.tx_ready = 1'b1;
      cycles(1);
      bus.tx_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) found = 1'b1;
      end
      check("s4_done_seen", 64'(found), 64'd1);
      bus.tx_data = 16'h3C5A; bus.tx_cd = 1'b0; bus.tx_ready = 1'b1;
      cycles(1);
      bus.tx_ready = 1'b0;
      cycles(90);
      check("s4_dead_gap", 64'(last_gap), 64'd1);
      check("s4_done_pulses", 64'(done_cnt), 64'd2);

      // Reset mid-word with the request held high.
      clear_counts();
      bus.tx_data = 16'h7E81; bus.tx_ready = 1'b1;
      cycles(1 + 20 * D);
      reset = 1'b1;
      cycles(1);
      check("s5_reset_outputs", 64'({bus.tx_en, bus.tx_p, bus.tx_n, bus.busy, bus.done, bus.drop}), 64'd0);
      reset = 1'b0;
      en_cnt = 0;
      cycles(20);
      check("s5_no_launch", 64'(en_cnt), 64'd0);
      bus.tx_ready = 1'b0;
      cycles(1);
      bus.tx_ready = 1'b1;
      cycles(3);
      check("s5_relaunch_busy", 64'(bus.busy), 64'd1);
      bus.tx_ready = 1'b0;
      cycles(85);

      // Input change after accept must not reach the line.
      clear_counts();
      bus.tx_data = 16'h0000; bus.tx_cd = 1'b0; bus.tx_ready = 1'b1;
      cycles(1);
      bus.tx_data = 16'hFFFF; bus.tx_cd = 1'b1; bus.tx_ready = 1'b0;
      cycles(90);
      check("s6_done_pulses", 64'(done_cnt), 64'd1);

      // Random requests, data and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) bus.tx_ready = ~bus.tx_ready;
         bus.tx_data = 16'($urandom);
         bus.tx_cd   = 1'($urandom_range(0, 1));
         reset       = ($urandom_range(0, 499) == 0);
         cycles(1);
      end
      reset = 1'b0;
      bus.tx_ready = 1'b0;
      cycles(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
